// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, instruction
// field positions, FSM state encodings and opcode decode helpers.
package alu_issue_ctrl_pkg;

    localparam int AW = 3;

    localparam logic [4:0] OP_NOP = 5'h00;
    localparam logic [4:0] OP_ADD = 5'h01;
    localparam logic [4:0] OP_SUB = 5'h02;
    localparam logic [4:0] OP_AND = 5'h03;
    localparam logic [4:0] OP_OR  = 5'h04;
    localparam logic [4:0] OP_NOT = 5'h05;
    localparam logic [4:0] OP_NEG = 5'h06;
    localparam logic [4:0] OP_HLT = 5'h1F;

    localparam int INSTR_OPC_HI  = 15;
    localparam int INSTR_OPC_LO  = 11;
    localparam int INSTR_RD_HI   = 10;
    localparam int INSTR_RD_LO   = 8;
    localparam int INSTR_RA_HI   = 7;
    localparam int INSTR_RA_LO   = 5;
    localparam int INSTR_RB_HI   = 4;
    localparam int INSTR_RB_LO   = 2;
    localparam int INSTR_RSVD_HI = 1;
    localparam int INSTR_RSVD_LO = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

    typedef struct packed {
        logic [4:0]    opc;
        logic [AW-1:0] rd;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
    } instr_fields_t;

    function automatic instr_fields_t decode_instr(input logic [15:0] raw);
        instr_fields_t f;
        f.opc = raw[INSTR_OPC_HI:INSTR_OPC_LO];
        f.rd  = raw[INSTR_RD_HI:INSTR_RD_LO];
        f.ra  = raw[INSTR_RA_HI:INSTR_RA_LO];
        f.rb  = raw[INSTR_RB_HI:INSTR_RB_LO];
        return f;
    endfunction

    // Only these opcodes produce a result worth retiring into rd and flags.
    function automatic logic op_writes(input logic [4:0] opc);
        logic w;
        case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_NEG: w = 1'b1;
            default:                                       w = 1'b0;
        endcase
        return w;
    endfunction

    function automatic logic op_unary(input logic [4:0] opc);
        return (opc == OP_NOT) || (opc == OP_NEG);
    endfunction

endpackage

// File: rtl/regfile_8x32.sv
// Register file: two combinational operand read ports, one debug read port
// and a single synchronous write port; cleared by synchronous reset.
module regfile_8x32
    import alu_issue_ctrl_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] ra_addr,
    output logic [DW-1:0] ra_data,
    input  logic [AW-1:0] rb_addr,
    output logic [DW-1:0] rb_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    logic [DW-1:0] mem_r [NREGS];

    // Storage update: clear everything on reset, otherwise single-port write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign ra_data  = mem_r[ra_addr];
    assign rb_data  = mem_r[rb_addr];
    assign dbg_data = mem_r[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the combinational ALU: accepts one instruction at a
// time, drives operands from the register file and retires result and flags.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [15:0]   instr,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic [4:0]    alu_opcode,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_r,
    input  logic          alu_c,
    input  logic          alu_s,
    input  logic          alu_o,
    input  logic          alu_z,
    output logic [3:0]    flags,
    output logic          done,
    output logic          halted,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    instr_fields_t instr_r;
    logic [3:0]    flags_r;
    logic          done_r;
    logic          halted_r;

    logic          accept_s;
    logic          in_exec_s;
    logic          retire_wr_s;
    logic          wr_en_s;
    logic [AW-1:0] wr_addr_s;
    logic [DW-1:0] wr_data_s;
    logic [DW-1:0] ra_data_s;
    logic [DW-1:0] rb_data_s;
    logic [4:0]    alu_opcode_s;
    logic [DW-1:0] alu_a_s;
    logic [DW-1:0] alu_b_s;
    logic          unused_rsvd_s;

    assign unused_rsvd_s = ^instr[INSTR_RSVD_HI:INSTR_RSVD_LO];

    assign instr_ready = (state_r == ST_IDLE);
    assign accept_s    = instr_valid && (state_r == ST_IDLE);
    assign in_exec_s   = (state_r == ST_EXEC);
    assign retire_wr_s = in_exec_s && op_writes(instr_r.opc);

    // Next-state decode; HALT is only left through reset.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (instr_r.opc == OP_HLT) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_WB;
                end
            end
            ST_WB:   state_nxt_s = ST_IDLE;
            ST_HALT: state_nxt_s = ST_HALT;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // ALU drive: operands only during EXEC, unary ops see a zero B operand.
    always_comb begin
        alu_opcode_s = OP_NOP;
        alu_a_s      = {DW{1'b0}};
        alu_b_s      = {DW{1'b0}};
        if (in_exec_s) begin
            alu_opcode_s = instr_r.opc;
            alu_a_s      = ra_data_s;
            if (op_unary(instr_r.opc)) begin
                alu_b_s = {DW{1'b0}};
            end else begin
                alu_b_s = rb_data_s;
            end
        end else begin
            alu_opcode_s = OP_NOP;
            alu_a_s      = {DW{1'b0}};
            alu_b_s      = {DW{1'b0}};
        end
    end

    // Write-source mux: loads and writebacks live in disjoint states.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = {AW{1'b0}};
        wr_data_s = {DW{1'b0}};
        if (retire_wr_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = instr_r.rd;
            wr_data_s = alu_r;
        end else if (ld_en && (state_r == ST_IDLE)) begin
            wr_en_s   = 1'b1;
            wr_addr_s = ld_addr;
            wr_data_s = ld_data;
        end else begin
            wr_en_s   = 1'b0;
            wr_addr_s = {AW{1'b0}};
            wr_data_s = {DW{1'b0}};
        end
    end

    // Control state, latched instruction, flags and retirement strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            instr_r  <= '{opc: OP_NOP, rd: {AW{1'b0}}, ra: {AW{1'b0}}, rb: {AW{1'b0}}};
            flags_r  <= 4'b0000;
            done_r   <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                instr_r <= decode_instr(instr);
            end
            if (retire_wr_s) begin
                flags_r <= {alu_c, alu_s, alu_o, alu_z};
            end
            // Leaving EXEC always retires; the pulse lands in WB or first HALT cycle.
            done_r <= in_exec_s;
            if (in_exec_s && (instr_r.opc == OP_HLT)) begin
                halted_r <= 1'b1;
            end
        end
    end

    regfile_8x32 #(
        .NREGS (NREGS),
        .DW    (DW)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (wr_en_s),
        .waddr    (wr_addr_s),
        .wdata    (wr_data_s),
        .ra_addr  (instr_r.ra),
        .ra_data  (ra_data_s),
        .rb_addr  (instr_r.rb),
        .rb_data  (rb_data_s),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    assign alu_opcode = alu_opcode_s;
    assign alu_a      = alu_a_s;
    assign alu_b      = alu_b_s;
    assign flags      = flags_r;
    assign done       = done_r;
    assign halted     = halted_r;

endmodule
